// File: rtl/ysyx_23060201_mem_arb.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with a one-entry request buffer.
// Round-robin tie-break, single outstanding transaction, combinational response forwarding.
module ysyx_23060201_mem_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // IFU (read-only master)
    input  logic                    ifu_req_valid_i,
    output logic                    ifu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
    output logic                    ifu_resp_valid_o,
    input  logic                    ifu_resp_ready_i,
    output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
    // LSU
    input  logic                    lsu_req_valid_i,
    output logic                    lsu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic                    lsu_wen_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
    output logic                    lsu_resp_valid_o,
    input  logic                    lsu_resp_ready_i,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    // memory slave
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_wen_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
    input  logic                    mem_resp_valid_i,
    output logic                    mem_resp_ready_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o
);
    localparam int MASK_W = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q,  last_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  wen_q,   wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0]     wmask_q, wmask_d;

    logic in_idle, in_issue, in_wait;
    logic win_ifu, win_lsu;
    logic resp_hs;

    assign in_idle  = (state_q == IDLE);
    assign in_issue = (state_q == ISSUE);
    assign in_wait  = (state_q == WAIT);

    // On a tie the master that was not served last wins (last_q: 0 = IFU, 1 = LSU).
    assign win_lsu = lsu_req_valid_i & (~ifu_req_valid_i | ~last_q);
    assign win_ifu = ifu_req_valid_i & (~lsu_req_valid_i |  last_q);

    assign ifu_req_ready_o = in_idle & win_ifu;
    assign lsu_req_ready_o = in_idle & win_lsu;

    assign mem_req_valid_o  = in_issue;
    assign mem_addr_o       = addr_q;
    assign mem_wen_o        = wen_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wmask_o      = wmask_q;
    assign mem_resp_ready_o = in_wait & (owner_q ? lsu_resp_ready_i : ifu_resp_ready_i);

    assign ifu_resp_valid_o = in_wait & ~owner_q & mem_resp_valid_i;
    assign lsu_resp_valid_o = in_wait &  owner_q & mem_resp_valid_i;
    assign ifu_rdata_o      = (in_wait & ~owner_q) ? mem_rdata_i : '0;
    assign lsu_rdata_o      = (in_wait &  owner_q) ? mem_rdata_i : '0;

    assign busy_o  = ~in_idle;
    assign resp_hs = mem_resp_valid_i & mem_resp_ready_o;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (lsu_req_ready_o) begin
                    state_d = ISSUE;
                    owner_d = 1'b1;
                    addr_d  = lsu_addr_i;
                    wen_d   = lsu_wen_i;
                    wdata_d = lsu_wdata_i;
                    wmask_d = lsu_wmask_i;
                end else if (ifu_req_ready_o) begin
                    state_d = ISSUE;
                    owner_d = 1'b0;
                    addr_d  = ifu_addr_i;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            ISSUE: if (mem_req_ready_i) state_d = WAIT;
            WAIT: begin
                if (resp_hs) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end
endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter: per-cycle vector table plus
// hand-written sequences for stalls and mid-transaction reset.
module tb_ysyx_23060201_mem_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy;

    always #5 clk = ~clk;

    ysyx_23060201_mem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready), .ifu_addr_i(ifu_addr),
        .ifu_resp_valid_o(ifu_resp_valid), .ifu_resp_ready_i(ifu_resp_ready), .ifu_rdata_o(ifu_rdata),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready), .lsu_addr_i(lsu_addr),
        .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask),
        .lsu_resp_valid_o(lsu_resp_valid), .lsu_resp_ready_i(lsu_resp_ready), .lsu_rdata_o(lsu_rdata),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr),
        .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int hs_cnt   = 0;

    always @(posedge clk) if (mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%b required=%b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    typedef struct {
        // stimulus
        bit iv; bit [31:0] ia; bit lv; bit [31:0] la;
        bit mrq; bit mrv; bit [31:0] mrd; bit irr; bit lrr;
        // expected
        bit irdy; bit lrdy; bit mv; bit [31:0] maddr; bit mrr;
        bit irv; bit [31:0] ird; bit lrv; bit [31:0] lrd; bit bsy;
    } vec_t;

    vec_t tv[16];

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- table: iv ia lv la mrq mrv mrd irr lrr | irdy lrdy mv maddr mrr irv ird lrv lrd busy
        // both valid after reset: LSU, IFU, LSU, IFU
        tv[0]  = '{1,32'h80000000,1,32'h80002000,1,0,32'h0,1,1,        0,1,0,32'h0,0,0,32'h0,0,32'h0,0};
        tv[1]  = '{1,32'h80000000,1,32'h80002004,1,0,32'h0,1,1,        0,0,1,32'h80002000,0,0,32'h0,0,32'h0,1};
        tv[2]  = '{1,32'h80000000,1,32'h80002004,0,1,32'h11111111,1,1, 0,0,0,32'h80002000,1,0,32'h0,1,32'h11111111,1};
        tv[3]  = '{1,32'h80000000,1,32'h80002004,1,0,32'h0,1,1,        1,0,0,32'h80002000,0,0,32'h0,0,32'h0,0};
        tv[4]  = '{1,32'h80000004,1,32'h80002004,1,0,32'h0,1,1,        0,0,1,32'h80000000,0,0,32'h0,0,32'h0,1};
        tv[5]  = '{1,32'h80000004,1,32'h80002004,0,1,32'h00000413,1,1, 0,0,0,32'h80000000,1,1,32'h00000413,0,32'h0,1};
        tv[6]  = '{1,32'h80000004,1,32'h80002004,1,0,32'h0,1,1,        0,1,0,32'h80000000,0,0,32'h0,0,32'h0,0};
        tv[7]  = '{1,32'h80000004,1,32'h80002008,1,0,32'h0,1,1,        0,0,1,32'h80002004,0,0,32'h0,0,32'h0,1};
        tv[8]  = '{1,32'h80000004,1,32'h80002008,0,1,32'h22222222,1,1, 0,0,0,32'h80002004,1,0,32'h0,1,32'h22222222,1};
        tv[9]  = '{1,32'h80000004,1,32'h80002008,1,0,32'h0,1,1,        1,0,0,32'h80002004,0,0,32'h0,0,32'h0,0};
        tv[10] = '{0,32'h0,0,32'h0,1,0,32'h0,1,1,                      0,0,1,32'h80000004,0,0,32'h0,0,32'h0,1};
        tv[11] = '{0,32'h0,0,32'h0,0,1,32'h33333333,1,1,               0,0,0,32'h80000004,1,1,32'h33333333,0,32'h0,1};
        // IFU-only fetch, 1-cycle memory: accept N, response N+2, idle N+3
        tv[12] = '{1,32'h80000000,0,32'h0,1,0,32'h0,1,1,               1,0,0,32'h80000004,0,0,32'h0,0,32'h0,0};
        tv[13] = '{0,32'h0,0,32'h0,1,0,32'h0,1,1,                      0,0,1,32'h80000000,0,0,32'h0,0,32'h0,1};
        tv[14] = '{0,32'h0,0,32'h0,0,1,32'h00000413,1,1,               0,0,0,32'h80000000,1,1,32'h00000413,0,32'h0,1};
        tv[15] = '{0,32'h0,0,32'h0,0,0,32'h0,1,1,                      0,0,0,32'h80000000,0,0,32'h0,0,32'h0,0};

        // ---------------- reset held with both masters requesting
        rst_n = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000000; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk1("rst ifu_req_ready", ifu_req_ready, 1'b0);
        chk1("rst lsu_req_ready", lsu_req_ready, 1'b1);
        chk1("rst mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst mem_resp_ready", mem_resp_ready, 1'b0);
        chk1("rst resp_valids", ifu_resp_valid | lsu_resp_valid, 1'b0);
        chk32("rst rdata_or", ifu_rdata | lsu_rdata, 32'h0);
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk1("rst busy", busy, 1'b0);
        chk32("rst mem_req hs", hs_cnt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ifu_req_valid  = tv[i].iv;  ifu_addr = tv[i].ia;
            lsu_req_valid  = tv[i].lv;  lsu_addr = tv[i].la;
            mem_req_ready  = tv[i].mrq; mem_resp_valid = tv[i].mrv; mem_rdata = tv[i].mrd;
            ifu_resp_ready = tv[i].irr; lsu_resp_ready = tv[i].lrr;
            #1;
            chk1($sformatf("v%0d ifu_req_ready", i), ifu_req_ready, tv[i].irdy);
            chk1($sformatf("v%0d lsu_req_ready", i), lsu_req_ready, tv[i].lrdy);
            chk1($sformatf("v%0d mem_req_valid", i), mem_req_valid, tv[i].mv);
            chk32($sformatf("v%0d mem_addr", i), mem_addr, tv[i].maddr);
            chk1($sformatf("v%0d mem_resp_ready", i), mem_resp_ready, tv[i].mrr);
            chk1($sformatf("v%0d ifu_resp_valid", i), ifu_resp_valid, tv[i].irv);
            chk32($sformatf("v%0d ifu_rdata", i), ifu_rdata, tv[i].ird);
            chk1($sformatf("v%0d lsu_resp_valid", i), lsu_resp_valid, tv[i].lrv);
            chk32($sformatf("v%0d lsu_rdata", i), lsu_rdata, tv[i].lrd);
            chk1($sformatf("v%0d busy", i), busy, tv[i].bsy);
            @(negedge clk);
        end

        // ---------------- LSU store with 5-cycle mem_req_ready stall
        begin
            int h0;
            lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
            lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF; mem_req_ready = 1'b0;
            #1 chk1("st accept", lsu_req_ready, 1'b1);
            h0 = hs_cnt;
            @(negedge clk);
            lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
            for (int c = 0; c < 5; c++) begin
                #1;
                chk1($sformatf("st%0d mem_req_valid", c), mem_req_valid, 1'b1);
                chk32($sformatf("st%0d mem_addr", c), mem_addr, 32'h80001000);
                chk1($sformatf("st%0d mem_wen", c), mem_wen, 1'b1);
                chk32($sformatf("st%0d mem_wdata", c), mem_wdata, 32'hDEADBEEF);
                chk32($sformatf("st%0d mem_wmask", c), 32'(mem_wmask), 32'hF);
                @(negedge clk);
            end
            mem_req_ready = 1'b1;
            #1 chk1("st release mem_req_valid", mem_req_valid, 1'b1);
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0;
            #1 chk1("st lsu_resp_valid", lsu_resp_valid, 1'b1);
            chk1("st no ifu resp", ifu_resp_valid, 1'b0);
            @(negedge clk);
            mem_resp_valid = 1'b0;
            #1 chk32("st mem hs count", hs_cnt - h0, 1);
            chk1("st back idle", busy, 1'b0);
        end

        // ---------------- IFU holds resp_ready low in WAIT; LSU waits
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000010;
        #1 chk1("is accept", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hABCD0123;
        ifu_resp_ready = 1'b0; lsu_req_valid = 1'b1; lsu_addr = 32'h80003000; lsu_wen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1($sformatf("is%0d busy", c), busy, 1'b1);
            chk1($sformatf("is%0d ifu_resp_valid", c), ifu_resp_valid, 1'b1);
            chk32($sformatf("is%0d ifu_rdata", c), ifu_rdata, 32'hABCD0123);
            chk1($sformatf("is%0d lsu_req_ready", c), lsu_req_ready, 1'b0);
            chk1($sformatf("is%0d mem_resp_ready", c), mem_resp_ready, 1'b0);
            @(negedge clk);
        end
        ifu_resp_ready = 1'b1;
        #1 chk1("is mem_resp_ready", mem_resp_ready, 1'b1);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1 chk1("is lsu accepted in idle", lsu_req_ready, 1'b1);
        @(negedge clk);
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1 chk32("is lsu mem_addr", mem_addr, 32'h80003000);
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h55555555;
        #1 chk32("is lsu_rdata", lsu_rdata, 32'h55555555);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        // ---------------- reset pulse while in WAIT
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000020;
        @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1 chk1("rw in wait busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rw busy", busy, 1'b0);
        chk1("rw ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk1("rw lsu_resp_valid", lsu_resp_valid, 1'b0);
        chk1("rw mem_resp_ready", mem_resp_ready, 1'b0);
        chk1("rw mem_req_valid", mem_req_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000030;
        #1 chk1("rw ifu accept", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1 chk32("rw mem_addr", mem_addr, 32'h80000030);
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h12345678;
        #1 chk1("rw ifu_resp_valid", ifu_resp_valid, 1'b1);
        chk32("rw ifu_rdata", ifu_rdata, 32'h12345678);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1 chk1("rw done idle", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ysyx_23060201_mem_arb.md
# ysyx_23060201_mem_arb

Two-master, one-slave memory arbiter sharing the single data memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It uses a valid/ready request and response handshake on every side. It accepts one request at a time into an internal request buffer, issues it to memory, and routes the response back to the owning master. Ties are resolved round-robin. At most one transaction is outstanding.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake (read-only master)
- ifu_addr  in  ADDR_WIDTH  IFU fetch address
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_WIDTH  fetched instruction
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_WIDTH  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_wmask  in  DATA_WIDTH/8  byte-enable for stores
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake
- lsu_rdata  out  DATA_WIDTH  load data (don't-care for stores)
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_WIDTH, 1, DATA_WIDTH, DATA_WIDTH/8  buffered request
- mem_resp_valid / mem_resp_ready  in / out  1  memory response handshake
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever state != IDLE

## Operation
- State machine:
  - IDLE: accepts a new request.
  - ISSUE: drives the buffered request to memory.
  - WAIT: waits for the memory response and forwards it.
- Registers:
  - state
  - owner (0 = IFU, 1 = LSU)
  - last (last owner granted)
  - req buffer: addr, wen, wdata, wmask
- IDLE arbitration (combinational):
  - Only IFU valid: IFU wins.
  - Only LSU valid: LSU wins.
  - Both valid: the master != last wins.
- IDLE handshake:
  - Only the winner's req_ready = 1; the loser's req_ready = 0.
  - On winner handshake: latch the request into the buffer and set owner = winner.
  - IFU requests latch wen = 0 and wmask = 0.
  - Next state is ISSUE.
- ISSUE:
  - mem_req_valid = 1; mem_* are driven from the buffer only.
  - Both master req_ready = 0.
  - On mem_req_ready: go to WAIT.
- WAIT:
  - mem_resp_ready = owner's resp_ready.
  - Owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata.
  - On mem response handshake: last = owner, go to IDLE.
- Non-owner outputs: resp_valid = 0 and rdata = 0 at all times.
- mem_req_valid = 0 and mem_resp_ready = 0 outside ISSUE and WAIT respectively.
- Master-side fields are not sampled after the accept handshake. Masters may change them freely after acceptance.
- Reset is asynchronous and takes effect at any time, including mid-transaction. The in-flight transaction is dropped with no response, and the memory slave is reset by the same rst_n.

## Timing
- Reset values:
  - state = IDLE, owner = 0, last = 0.
  - Buffer = 0.
  - All valid/ready outputs = 0 except the IDLE winner's combinational req_ready.
  - rdata outputs = 0, busy = 0.
- With reset last = 0, LSU wins the first simultaneous request.
- Accept in cycle N; mem_req_valid asserted in N+1.
- Response forwarding is combinational: the owner sees resp_valid in the same cycle mem_resp_valid rises.
- Minimum round trip, assuming mem_req_ready = 1 in N+1 and mem_resp_valid in N+2 with the owner ready:
  - Response in N+2.
  - Back in IDLE at N+3.
  - Next accept possible at N+3.
  - Peak throughput is one transaction per 3 cycles.
- Back-pressure:
  - mem_req_ready low holds ISSUE with stable mem_*.
  - Owner resp_ready low holds WAIT; the memory must hold mem_rdata stable.
- Simultaneous events:
  - A request arriving while busy waits in IDLE-less states with req_ready = 0; no request is lost.
  - A master's req_valid arriving in the same cycle the FSM enters IDLE is arbitrated in that IDLE cycle.

## Test plan
- Reset with both valids high:
  - During rst_n = 0: all handshake outputs 0 except the combinational LSU req_ready, and no state change.
  - After release: LSU accepted first (last = 0); mem_addr equals lsu_addr one cycle later.
- IFU-only fetch, ifu_addr = 0x80000000, memory with 1-cycle response returning 0x00000413:
  - ifu_rdata = 0x00000413 with ifu_resp_valid at N+2.
  - lsu_resp_valid stays 0.
- Both masters request continuously:
  - Grants alternate LSU, IFU, LSU, IFU.
  - Each mem_addr matches the granted master's address.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, with mem_req_ready held 0 for 5 cycles:
  - mem_* stable throughout the stall.
  - Exactly one mem request handshake.
- IFU holds resp_ready = 0 for 3 cycles:
  - FSM stays in WAIT.
  - ifu_rdata stays stable.
  - An LSU request during the stall is not accepted until back in IDLE.
- rst_n pulsed low while in WAIT:
  - State returns to IDLE immediately.
  - No response is delivered to either master.
  - A subsequent IFU request completes normally.
